// File: rtl/jelly_rtos_ready_queue.sv
//==============================================================================
// Module   : jelly_rtos_ready_queue
// Purpose  : Sorted ready queue of task IDs (ADD/DEL/POP/ROTATE) with FIFO tie-break.
// Revision : 1.0
//==============================================================================
`default_nettype none

module jelly_rtos_ready_queue #(
   parameter int N          = 16,
   parameter int ID_WIDTH   = 32,
   parameter int PRI_WIDTH  = 4,
   parameter int PRI_ASCEND = 1,
   parameter int N_WIDTH    = $clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cke,
   input  logic [1:0]           in_op,
   input  logic [ID_WIDTH-1:0]  in_id,
   input  logic [PRI_WIDTH-1:0] in_pri,
   input  logic                 in_valid,
   output logic [ID_WIDTH-1:0]  top_id,
   output logic [PRI_WIDTH-1:0] top_pri,
   output logic                 top_valid,
   output logic [N_WIDTH-1:0]   size,
   output logic                 full,
   output logic [ID_WIDTH-1:0]  out_id,
   output logic                 out_valid,
   output logic                 err,
   output logic [1:0]           err_code
);

   localparam logic [1:0] c_OP_ADD = 2'd0;
   localparam logic [1:0] c_OP_DEL = 2'd1;
   localparam logic [1:0] c_OP_POP = 2'd2;
   localparam logic [1:0] c_OP_ROT = 2'd3;

   localparam logic [1:0] c_ERR_FULL      = 2'd0;
   localparam logic [1:0] c_ERR_DUP       = 2'd1;
   localparam logic [1:0] c_ERR_NOT_FOUND = 2'd2;
   localparam logic [1:0] c_ERR_EMPTY     = 2'd3;

   localparam logic [N_WIDTH-1:0] c_ONE = N_WIDTH'(1);
   localparam logic [N_WIDTH-1:0] c_N   = N_WIDTH'(N);

   logic [ID_WIDTH-1:0]  r_id  [N];
   logic [PRI_WIDTH-1:0] r_pri [N];
   logic [N-1:0]         r_vld;
   logic [N_WIDTH-1:0]   r_size;
   logic                 r_full;
   logic [ID_WIDTH-1:0]  r_out_id;
   logic                 r_out_valid;
   logic                 r_err;
   logic [1:0]           r_err_code;

   logic [ID_WIDTH-1:0]  w_up_id  [N];
   logic [PRI_WIDTH-1:0] w_up_pri [N];
   logic [ID_WIDTH-1:0]  w_dn_id  [N];
   logic [PRI_WIDTH-1:0] w_dn_pri [N];

   logic [ID_WIDTH-1:0]  w_nxt_id  [N];
   logic [PRI_WIDTH-1:0] w_nxt_pri [N];
   logic [N-1:0]         w_nxt_vld;
   logic [N_WIDTH-1:0]   w_nxt_size;

   logic                 w_hit;
   logic [N_WIDTH-1:0]   w_hit_idx;
   logic [N_WIDTH-1:0]   w_ins_pos;
   logic [N_WIDTH-1:0]   w_rot_cnt;
   logic                 w_rm_en;
   logic [N_WIDTH-1:0]   w_rm_idx;
   logic                 w_pop;
   logic                 w_rej;
   logic [1:0]           w_rej_code;

   // True when priority a ranks equal to or ahead of priority b.
   function automatic logic f_ahead(input logic [PRI_WIDTH-1:0] a, input logic [PRI_WIDTH-1:0] b);
      if (PRI_ASCEND != 0) return (a <= b);
      else                 return (a >= b);
   endfunction

   // Shifted views of the array: up closes a gap, dn opens one.
   for (genvar gi = 0; gi < N; gi++) begin : g_shift
      if (gi < N - 1) begin : g_up
         assign w_up_id[gi]  = r_id[gi+1];
         assign w_up_pri[gi] = r_pri[gi+1];
      end else begin : g_up_last
         assign w_up_id[gi]  = '0;
         assign w_up_pri[gi] = '0;
      end
      if (gi > 0) begin : g_dn
         assign w_dn_id[gi]  = r_id[gi-1];
         assign w_dn_pri[gi] = r_pri[gi-1];
      end else begin : g_dn_first
         assign w_dn_id[gi]  = '0;
         assign w_dn_pri[gi] = '0;
      end
   end

   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_ins_pos = '0;
      w_rot_cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (r_vld[i] && (r_id[i] == in_id)) begin
            w_hit     = 1'b1;
            w_hit_idx = N_WIDTH'(i);
         end
         // Sorted and contiguous, so these counts are prefix lengths.
         if (r_vld[i] && f_ahead(r_pri[i], in_pri)) w_ins_pos = w_ins_pos + c_ONE;
         if (r_vld[i] && (r_pri[i] == r_pri[0]))    w_rot_cnt = w_rot_cnt + c_ONE;
      end
   end

   always_comb begin
      w_nxt_id   = r_id;
      w_nxt_pri  = r_pri;
      w_nxt_size = r_size;
      w_nxt_vld  = '0;
      w_rm_en    = 1'b0;
      w_rm_idx   = '0;
      w_pop      = 1'b0;
      w_rej      = 1'b0;
      w_rej_code = r_err_code;

      if (in_valid) begin
         case (in_op)
            c_OP_ADD: begin
               if (r_full) begin
                  w_rej      = 1'b1;
                  w_rej_code = c_ERR_FULL;
               end else if (w_hit) begin
                  w_rej      = 1'b1;
                  w_rej_code = c_ERR_DUP;
               end else begin
                  for (int i = 0; i < N; i++) begin
                     if (N_WIDTH'(i) == w_ins_pos) begin
                        w_nxt_id[i]  = in_id;
                        w_nxt_pri[i] = in_pri;
                     end else if (N_WIDTH'(i) > w_ins_pos) begin
                        w_nxt_id[i]  = w_dn_id[i];
                        w_nxt_pri[i] = w_dn_pri[i];
                     end
                  end
                  w_nxt_size = r_size + c_ONE;
               end
            end
            c_OP_DEL: begin
               if (!w_hit) begin
                  w_rej      = 1'b1;
                  w_rej_code = c_ERR_NOT_FOUND;
               end else begin
                  w_rm_en  = 1'b1;
                  w_rm_idx = w_hit_idx;
               end
            end
            c_OP_POP: begin
               if (!r_vld[0]) begin
                  w_rej      = 1'b1;
                  w_rej_code = c_ERR_EMPTY;
               end else begin
                  w_rm_en = 1'b1;
                  w_pop   = 1'b1;
               end
            end
            default: begin
               if (!r_vld[0]) begin
                  w_rej      = 1'b1;
                  w_rej_code = c_ERR_EMPTY;
               end else if (w_rot_cnt > c_ONE) begin
                  for (int i = 0; i < N; i++) begin
                     if ((N_WIDTH'(i) + c_ONE) < w_rot_cnt) begin
                        w_nxt_id[i]  = w_up_id[i];
                        w_nxt_pri[i] = w_up_pri[i];
                     end else if ((N_WIDTH'(i) + c_ONE) == w_rot_cnt) begin
                        w_nxt_id[i]  = r_id[0];
                        w_nxt_pri[i] = r_pri[0];
                     end
                  end
               end
            end
         endcase
      end

      if (w_rm_en) begin
         for (int i = 0; i < N; i++) begin
            if (N_WIDTH'(i) >= w_rm_idx) begin
               w_nxt_id[i]  = w_up_id[i];
               w_nxt_pri[i] = w_up_pri[i];
            end
         end
         w_nxt_size = r_size - c_ONE;
      end

      for (int i = 0; i < N; i++) begin
         w_nxt_vld[i] = (N_WIDTH'(i) < w_nxt_size);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id        <= '{default: '0};
         r_pri       <= '{default: '0};
         r_vld       <= '0;
         r_size      <= '0;
         r_full      <= 1'b0;
         r_out_id    <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= '0;
      end else if (cke) begin
         r_id        <= w_nxt_id;
         r_pri       <= w_nxt_pri;
         r_vld       <= w_nxt_vld;
         r_size      <= w_nxt_size;
         r_full      <= (w_nxt_size == c_N);
         r_out_valid <= w_pop;
         r_err       <= w_rej;
         if (w_pop) r_out_id   <= r_id[0];
         if (w_rej) r_err_code <= w_rej_code;
      end
   end

   assign top_id    = r_id[0];
   assign top_pri   = r_pri[0];
   assign top_valid = r_vld[0];
   assign size      = r_size;
   assign full      = r_full;
   assign out_id    = r_out_id;
   assign out_valid = r_out_valid;
   assign err       = r_err;
   assign err_code  = r_err_code;

endmodule

`default_nettype wire
